// File: rtl/gpu_ram_mux_pkg.sv
// Shared types and constants for the GPU RAM host-port mux.
package gpu_mux_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 8;

  localparam logic CLIENT_HOST = 1'b0;
  localparam logic CLIENT_AUX  = 1'b1;

  // In-flight access tag; valid marks a read whose data must be returned.
  typedef struct packed {
    logic valid;
    logic client;
  } rd_tag_t;

  // True when the tag is a read belonging to the given client.
  function automatic logic is_read_for(rd_tag_t t, logic client);
    return t.valid && (t.client == client);
  endfunction

endpackage

// File: rtl/gpu_ram_mux_if.sv
// Host, aux and RAM-side signals of the GPU RAM mux, grouped as one bus.
interface gpu_ram_mux_if
  import gpu_mux_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // Z80 bridge side
  logic              host_wr_ena;
  logic              host_rd_req;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_rdy;
  logic              host_err;
  // auxiliary requester side
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic [DATA_W-1:0] aux_rd_data;
  logic              aux_rd_rdy;
  // RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // The mux itself
  modport slave (
    input  host_wr_ena, host_rd_req, host_addr, host_wdata,
    output host_rd_data, host_rd_rdy, host_err,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rd_data, aux_rd_rdy,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Clients plus RAM, seen from outside the mux
  modport master (
    output host_wr_ena, host_rd_req, host_addr, host_wdata,
    input  host_rd_data, host_rd_rdy, host_err,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rd_data, aux_rd_rdy,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/gpu_ram_mux_rd_tag_pipe.sv
// Fixed-depth shift pipe of access tags; the exiting tag lines up with
// the cycle in which the RAM presents read data for that access.
module rd_tag_pipe
  import gpu_mux_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic    i_clk,
  input  logic    i_clr,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t [DEPTH-1:0] r_pipe;

  // Shift one stage per cycle; clear discards everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/gpu_ram_mux.sv
// Arbitrates the GPU RAM host port between the Z80 bridge (fixed priority,
// one-shot pulses) and an aux requester (level req / pulsed grant), and
// routes read data back to whichever client issued the read.
module gpu_ram_mux
  import gpu_mux_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RAM_LATENCY = 2
)(
  input logic          GPU_CLK,
  input logic          reset,
  gpu_ram_mux_if.slave bus
);

  generate
    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
      $error("gpu_ram_mux: RAM_LATENCY must be 1..4");
    end
  endgenerate

  // ---- arbitration ----
  logic w_host_issue;
  logic w_aux_issue;

  // Host never waits, so aux only gets cycles the host leaves empty.
  assign w_host_issue = bus.host_wr_ena | bus.host_rd_req;
  assign w_aux_issue  = ~w_host_issue & bus.aux_req;

  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_client;
  logic              r_aux_gnt;
  logic              r_host_err;

  // Register the winning access onto the RAM port for the next cycle.
  always_ff @(posedge GPU_CLK) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_client    <= CLIENT_HOST;
      r_aux_gnt   <= 1'b0;
    end else begin
      r_ram_en  <= w_host_issue | w_aux_issue;
      r_aux_gnt <= w_aux_issue;
      if (w_host_issue) begin
        // a simultaneous read pulse is dropped: the write wins
        r_ram_we    <= bus.host_wr_ena;
        r_ram_addr  <= bus.host_addr;
        r_ram_wdata <= bus.host_wdata;
        r_client    <= CLIENT_HOST;
      end else if (w_aux_issue) begin
        r_ram_we    <= bus.aux_we;
        r_ram_addr  <= bus.aux_addr;
        r_ram_wdata <= bus.aux_wdata;
        r_client    <= CLIENT_AUX;
      end else begin
        r_ram_we    <= 1'b0;
      end
    end
  end

  // Sticky protocol error: host pulsed read and write together.
  always_ff @(posedge GPU_CLK) begin
    if (reset) r_host_err <= 1'b0;
    else       r_host_err <= r_host_err | (bus.host_wr_ena & bus.host_rd_req);
  end

  // ---- read tracking ----
  rd_tag_t w_tag_in;
  rd_tag_t w_tag_out;

  // Tag is pushed in the issue cycle, so it exits RAM_LATENCY cycles later
  // exactly when ram_rdata is valid.
  assign w_tag_in.valid  = r_ram_en & ~r_ram_we;
  assign w_tag_in.client = r_client;

  rd_tag_pipe #(.DEPTH(RAM_LATENCY)) u_tag_pipe (
    .i_clk (GPU_CLK),
    .i_clr (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  logic              w_ret_host;
  logic              w_ret_aux;
  logic              r_host_rdy;
  logic              r_aux_rdy;
  logic [DATA_W-1:0] r_host_data;
  logic [DATA_W-1:0] r_aux_data;

  assign w_ret_host = is_read_for(w_tag_out, CLIENT_HOST);
  assign w_ret_aux  = is_read_for(w_tag_out, CLIENT_AUX);

  // Capture returning data for its owner and pulse that owner's ready.
  always_ff @(posedge GPU_CLK) begin
    if (reset) begin
      r_host_rdy  <= 1'b0;
      r_aux_rdy   <= 1'b0;
      r_host_data <= '0;
      r_aux_data  <= '0;
    end else begin
      r_host_rdy <= w_ret_host;
      r_aux_rdy  <= w_ret_aux;
      if (w_ret_host) r_host_data <= bus.ram_rdata;
      if (w_ret_aux)  r_aux_data  <= bus.ram_rdata;
    end
  end

  assign bus.ram_en       = r_ram_en;
  assign bus.ram_we       = r_ram_we;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_wdata    = r_ram_wdata;
  assign bus.aux_gnt      = r_aux_gnt;
  assign bus.host_err     = r_host_err;
  assign bus.host_rd_rdy  = r_host_rdy;
  assign bus.host_rd_data = r_host_data;
  assign bus.aux_rd_rdy   = r_aux_rdy;
  assign bus.aux_rd_data  = r_aux_data;

endmodule
